// File: rtl/wb_arb_pkg.sv
// Shared constants for the writeback arbiter: port count and unit indices.
package wb_arb_pkg;

  localparam int PORTCOUNT = 4;

  localparam logic [1:0] ALU0 = 2'd0;
  localparam logic [1:0] ALU1 = 2'd1;
  localparam logic [1:0] CALU = 2'd2;
  localparam logic [1:0] LSU  = 2'd3;

  // Number of requesting units in a 4-bit request vector.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rr_picker4.sv
// Combinational rotating-priority picker: the search begins one port past
// the last winner and wraps 3 -> 0; the first requesting port wins.
module rr_picker4
  import wb_arb_pkg::*;
(
  input  logic [PORTCOUNT-1:0] req_i,
  input  logic [1:0]           last_i,
  output logic [PORTCOUNT-1:0] grant_o,
  output logic [1:0]           index_o,
  output logic                 valid_o
);

  logic [1:0] cand;

  // Walk ports last+1 .. last+4 (mod 4) and keep the first requester.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= PORTCOUNT; k++) begin
      cand = last_i + 2'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        index_o       = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Four-port writeback arbiter in front of a single register-file write port.
// One winner per advancing cycle; its address, data and tag appear on the
// outputs one cycle later, with the tag always retired and the register
// write suppressed for the zero register.
// Build option WB_ARB_LSU_PRIORITY_EN: the LSU wins whenever it requests,
// and round-robin rotation (LastGrant) only tracks ports 0-2.
module writeback_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATABITWIDTH    = 16,
  parameter int TAGBITWIDTH     = 6,
  parameter int REGADDRBITWIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 sync_rst,
  input  logic                                 clk_en,
  input  logic [PORTCOUNT-1:0]                 Req_Valid,
  output logic [PORTCOUNT-1:0]                 Req_Ready,
  input  logic [PORTCOUNT*REGADDRBITWIDTH-1:0] Req_RegAddr,
  input  logic [PORTCOUNT*DATABITWIDTH-1:0]    Req_Data,
  input  logic [PORTCOUNT*TAGBITWIDTH-1:0]     Req_Tag,
  output logic                                 RegWriteEn,
  output logic [REGADDRBITWIDTH-1:0]           RegWriteAddrOut,
  output logic [DATABITWIDTH-1:0]              RegWriteDataOut,
  output logic                                 TagFreeValid,
  output logic [TAGBITWIDTH-1:0]               TagFreeOut,
  output logic [1:0]                           GrantIndex,
  output logic                                 WritebackCongestionStallOut
);

  logic [REGADDRBITWIDTH-1:0] addr_a [PORTCOUNT];
  logic [DATABITWIDTH-1:0]    data_a [PORTCOUNT];
  logic [TAGBITWIDTH-1:0]     tag_a  [PORTCOUNT];

  for (genvar i = 0; i < PORTCOUNT; i++) begin : g_unpack
    assign addr_a[i] = Req_RegAddr[i*REGADDRBITWIDTH +: REGADDRBITWIDTH];
    assign data_a[i] = Req_Data[i*DATABITWIDTH +: DATABITWIDTH];
    assign tag_a[i]  = Req_Tag[i*TAGBITWIDTH +: TAGBITWIDTH];
  end

  logic [1:0]                 last_q, last_d;
  logic                       we_q, we_d;
  logic                       tv_q, tv_d;
  logic [REGADDRBITWIDTH-1:0] addr_q, addr_d;
  logic [DATABITWIDTH-1:0]    data_q, data_d;
  logic [TAGBITWIDTH-1:0]     tag_q, tag_d;
  logic [1:0]                 gidx_q, gidx_d;

  logic [PORTCOUNT-1:0] pick_req, pick_grant;
  logic [1:0]           pick_idx;
  logic                 pick_vld;
  logic [PORTCOUNT-1:0] win_oh;
  logic [1:0]           win_idx;
  logic                 win_vld;
  logic                 last_upd;
  logic                 xfer;

  rr_picker4 u_picker (
    .req_i   (pick_req),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .index_o (pick_idx),
    .valid_o (pick_vld)
  );

`ifdef WB_ARB_LSU_PRIORITY_EN
  assign pick_req = {1'b0, Req_Valid[CALU:ALU0]};

  // LSU overrides the rotation and leaves LastGrant untouched when it wins.
  always_comb begin
    if (Req_Valid[LSU]) begin
      win_oh   = 4'b1000;
      win_idx  = LSU;
      win_vld  = 1'b1;
      last_upd = 1'b0;
    end else begin
      win_oh   = pick_grant;
      win_idx  = pick_idx;
      win_vld  = pick_vld;
      last_upd = pick_vld;
    end
  end
`else
  assign pick_req = Req_Valid;
  assign win_oh   = pick_grant;
  assign win_idx  = pick_idx;
  assign win_vld  = pick_vld;
  assign last_upd = pick_vld;
`endif

  // No handshake while stalled or held in reset, so nothing is lost on release.
  assign xfer      = win_vld && clk_en && !sync_rst;
  assign Req_Ready = xfer ? win_oh : '0;

  assign WritebackCongestionStallOut = (popcount4(Req_Valid) >= 3'd2);

  // Next-state: capture the winner on a transfer, drop strobes on an idle advance.
  always_comb begin
    last_d = last_q;
    we_d   = we_q;
    tv_d   = tv_q;
    addr_d = addr_q;
    data_d = data_q;
    tag_d  = tag_q;
    gidx_d = gidx_q;
    if (clk_en) begin
      we_d = 1'b0;
      tv_d = 1'b0;
      if (xfer) begin
        we_d   = (addr_a[win_idx] != '0);
        tv_d   = 1'b1;
        addr_d = addr_a[win_idx];
        data_d = data_a[win_idx];
        tag_d  = tag_a[win_idx];
        gidx_d = win_idx;
        if (last_upd) begin
          last_d = win_idx;
        end
      end
    end
  end

  // State register; reset leaves port 0 at the head of the rotation.
  always_ff @(posedge clk or posedge sync_rst) begin
    if (sync_rst) begin
      last_q <= LSU;
      we_q   <= 1'b0;
      tv_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      gidx_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      tv_q   <= tv_d;
      addr_q <= addr_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      gidx_q <= gidx_d;
    end
  end

  assign RegWriteEn      = we_q;
  assign TagFreeValid    = tv_q;
  assign RegWriteAddrOut = addr_q;
  assign RegWriteDataOut = data_q;
  assign TagFreeOut      = tag_q;
  assign GrantIndex      = gidx_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations
// plus a long randomized run, all checked every cycle against a behavioural
// model of the arbitration rules.
module tb_writeback_arbiter;

  localparam int DW = 16;
  localparam int TW = 6;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sync_rst;
  logic          clk_en;
  logic [3:0]    pend;
  logic [AW-1:0] p_addr [4];
  logic [DW-1:0] p_data [4];
  logic [TW-1:0] p_tag  [4];

  logic [3:0]    Req_Valid, Req_Ready;
  logic [4*AW-1:0] Req_RegAddr;
  logic [4*DW-1:0] Req_Data;
  logic [4*TW-1:0] Req_Tag;
  logic          RegWriteEn, TagFreeValid, stall;
  logic [AW-1:0] RegWriteAddrOut;
  logic [DW-1:0] RegWriteDataOut;
  logic [TW-1:0] TagFreeOut;
  logic [1:0]    GrantIndex;

  assign Req_Valid   = pend;
  assign Req_RegAddr = {p_addr[3], p_addr[2], p_addr[1], p_addr[0]};
  assign Req_Data    = {p_data[3], p_data[2], p_data[1], p_data[0]};
  assign Req_Tag     = {p_tag[3], p_tag[2], p_tag[1], p_tag[0]};

  writeback_arbiter #(.DATABITWIDTH(DW), .TAGBITWIDTH(TW), .REGADDRBITWIDTH(AW)) dut (
    .clk                         (clk),
    .sync_rst                    (sync_rst),
    .clk_en                      (clk_en),
    .Req_Valid                   (Req_Valid),
    .Req_Ready                   (Req_Ready),
    .Req_RegAddr                 (Req_RegAddr),
    .Req_Data                    (Req_Data),
    .Req_Tag                     (Req_Tag),
    .RegWriteEn                  (RegWriteEn),
    .RegWriteAddrOut             (RegWriteAddrOut),
    .RegWriteDataOut             (RegWriteDataOut),
    .TagFreeValid                (TagFreeValid),
    .TagFreeOut                  (TagFreeOut),
    .GrantIndex                  (GrantIndex),
    .WritebackCongestionStallOut (stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who should win given the requests and the last winner.
  function automatic int model_winner(input logic [3:0] v, input int last);
`ifdef WB_ARB_LSU_PRIORITY_EN
    if (v[3]) return 3;
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (last + k) % 4;
      if (p != 3 && v[p]) return p;
    end
    return -1;
`else
    for (int k = 1; k <= 4; k++) begin
      int p;
      p = (last + k) % 4;
      if (v[p]) return p;
    end
    return -1;
`endif
  endfunction

  int            m_last;
  logic          m_we, m_tv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_tag;
  int            m_gidx;
  int            cw;
  logic [3:0]    cer;

  // Compare DUT against the model mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (sync_rst) begin
      m_last = 3; m_we = 0; m_tv = 0; m_addr = '0; m_data = '0; m_tag = '0; m_gidx = 0;
    end
    cw  = model_winner(pend, m_last);
    cer = (cw >= 0 && clk_en && !sync_rst) ? (4'b0001 << cw) : 4'b0000;
    chk("ready", 32'(Req_Ready), 32'(cer));
    chk("stall", 32'(stall), 32'($countones(pend) >= 2));
    chk("we", 32'(RegWriteEn), 32'(m_we));
    chk("tagvalid", 32'(TagFreeValid), 32'(m_tv));
    chk("addr", 32'(RegWriteAddrOut), 32'(m_addr));
    chk("data", 32'(RegWriteDataOut), 32'(m_data));
    chk("tag", 32'(TagFreeOut), 32'(m_tag));
    chk("gidx", 32'(GrantIndex), 32'(m_gidx));
    if (!sync_rst && clk_en) begin
      if (cw >= 0) begin
        m_we   = (p_addr[cw] != '0);
        m_tv   = 1'b1;
        m_addr = p_addr[cw];
        m_data = p_data[cw];
        m_tag  = p_tag[cw];
        m_gidx = cw;
`ifdef WB_ARB_LSU_PRIORITY_EN
        if (cw != 3) m_last = cw;
`else
        m_last = cw;
`endif
      end else begin
        m_we = 1'b0;
        m_tv = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] acc;

  initial begin
    sync_rst = 1'b1;
    clk_en   = 1'b1;
    pend     = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      p_addr[i] = AW'(i + 1);
      p_data[i] = DW'(16'h1000 + i);
      p_tag[i]  = TW'(i + 8);
    end
    repeat (3) cyc();
    chk("rst_we", 32'(RegWriteEn), 32'd0);
    chk("rst_gidx", 32'(GrantIndex), 32'd0);
    chk("rst_ready", 32'(Req_Ready), 32'd0);

    sync_rst = 1'b0;
`ifndef WB_ARB_LSU_PRIORITY_EN
    pend = 4'b1111;
    #1 chk("rr_first", 32'(Req_Ready), 32'b0001);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("rr_gidx", 32'(GrantIndex), 32'(i - 1));
      chk("rr_ready", 32'(Req_Ready), 32'(4'b0001 << i));
    end
    cyc();
    chk("rr_gidx3", 32'(GrantIndex), 32'd3);
    pend = 4'b0000;
`else
    pend = 4'b1001;
    #1 chk("lsu_first", 32'(Req_Ready), 32'b1000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lsu_gidx", 32'(GrantIndex), 32'd3);
      chk("lsu_ready", 32'(Req_Ready), 32'b1000);
    end
    pend = 4'b0001;
    #1 chk("lsu_drop", 32'(Req_Ready), 32'b0001);
    cyc();
    chk("lsu_drop_gidx", 32'(GrantIndex), 32'd0);
    pend = 4'b0000;
`endif

    p_addr[2] = 4'd5; p_data[2] = 16'hBEEF; p_tag[2] = 6'h21;
    pend = 4'b0100;
    #1 chk("p2_ready", 32'(Req_Ready), 32'b0100);
    cyc();
    pend = 4'b0000;
    chk("p2_we", 32'(RegWriteEn), 32'd1);
    chk("p2_addr", 32'(RegWriteAddrOut), 32'd5);
    chk("p2_data", 32'(RegWriteDataOut), 32'hBEEF);
    chk("p2_tag", 32'(TagFreeOut), 32'h21);
    chk("p2_tv", 32'(TagFreeValid), 32'd1);

    p_addr[1] = '0; p_tag[1] = 6'h15;
    pend = 4'b0010;
    cyc();
    pend = 4'b0000;
    chk("zero_we", 32'(RegWriteEn), 32'd0);
    chk("zero_tv", 32'(TagFreeValid), 32'd1);
    chk("zero_tag", 32'(TagFreeOut), 32'h15);
    cyc();
    chk("idle_tv", 32'(TagFreeValid), 32'd0);

    pend = 4'b0011;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_ready", 32'(Req_Ready), 32'd0);
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_tag", 32'(TagFreeOut), 32'h15);
    end
    clk_en = 1'b1;
    #1 chk("resume_ready", 32'(Req_Ready), 32'b0001);
    cyc();
    chk("resume_gidx", 32'(GrantIndex), 32'd0);
    pend = 4'b0010;
    cyc();
    pend = 4'b0000;

    p_addr[2] = 4'd7;
    pend = 4'b0100;
    cyc();
    pend = 4'b0000;
    chk("pre_rst_we", 32'(RegWriteEn), 32'd1);
    #1 sync_rst = 1'b1;
    #1;
    chk("async_we", 32'(RegWriteEn), 32'd0);
    chk("async_tv", 32'(TagFreeValid), 32'd0);
    chk("async_gidx", 32'(GrantIndex), 32'd0);
    cyc();
    sync_rst = 1'b0;
    p_addr[0] = 4'd3; p_addr[1] = 4'd4;
    pend = 4'b0111;
    #1 chk("post_rst_ready", 32'(Req_Ready), 32'b0001);
    cyc();
    chk("post_rst_gidx", 32'(GrantIndex), 32'd0);
    pend = 4'b0000;
    cyc();

    for (int n = 0; n < 3000; n++) begin
      clk_en = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          p_addr[i] = AW'($urandom);
          p_data[i] = DW'($urandom);
          p_tag[i]  = TW'($urandom);
        end
      end
      @(negedge clk);
      acc = Req_Ready & pend;
      @(posedge clk);
      #1;
      pend = pend & ~acc;
    end

    pend = 4'b0000;
    clk_en = 1'b1;
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter DATABITWIDTH, default 16, register data width.
REQ-002 SHALL have parameter TAGBITWIDTH, default 6, instruction tag width.
REQ-003 SHALL have parameter REGADDRBITWIDTH, default 4, register address width.
REQ-004 SHALL have port clk, input, 1, sole clock; one clock, all state on rising edge.
REQ-005 SHALL have port sync_rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port clk_en, input, 1, pipeline advance enable.
REQ-007 SHALL have port Req_Valid, input, 4, per-unit writeback request (0 ALU0, 1 ALU1, 2 Complex ALU, 3 LSU).
REQ-008 SHALL have port Req_Ready, output, 4, per-unit grant/accept.
REQ-009 SHALL have port Req_RegAddr, input, 4*REGADDRBITWIDTH, packed destination addresses, port i at slice i.
REQ-010 SHALL have port Req_Data, input, 4*DATABITWIDTH, packed writeback data.
REQ-011 SHALL have port Req_Tag, input, 4*TAGBITWIDTH, packed instruction tags.
REQ-012 SHALL have port RegWriteEn, output, 1, register-file write strobe.
REQ-013 SHALL have port RegWriteAddrOut, output, REGADDRBITWIDTH, write address.
REQ-014 SHALL have port RegWriteDataOut, output, DATABITWIDTH, write data.
REQ-015 SHALL have port TagFreeValid, output, 1, tag retirement strobe.
REQ-016 SHALL have port TagFreeOut, output, TAGBITWIDTH, retired tag.
REQ-017 SHALL have port GrantIndex, output, 2, unit that produced the current output.
REQ-018 SHALL have port WritebackCongestionStallOut, output, 1, issue stall request.

Function
REQ-019 Handshake: transfer on port i iff Req_Valid[i] && Req_Ready[i]; at most one Req_Ready bit high per cycle.
REQ-020 Req_Ready SHALL be combinational: all zero when clk_en=0 or no request; else one-hot on winner.
REQ-021 Round-robin: search starts at (LastGrant+1) mod 4, wraps 3->0; first valid port wins.
REQ-022 LastGrant SHALL update to the winner only on a transfer with clk_en=1.
REQ-023 Latency: winner's addr/data/tag registered; outputs valid exactly 1 cycle after transfer.
REQ-024 Cycle after transfer: TagFreeValid=1; RegWriteEn=1 unless winner addr was 0 (zero register), then RegWriteEn=0, tag still freed.
REQ-025 Cycle after no transfer (clk_en=1): RegWriteEn=0, TagFreeValid=0; addr/data/tag/GrantIndex hold previous values.
REQ-026 clk_en=0: all registers, LastGrant included, hold; no transfer occurs.
REQ-027 WritebackCongestionStallOut SHALL be combinational: 1 when popcount(Req_Valid) >= 2, else 0.
REQ-028 Requests not granted SHALL not be dropped; requester holds Req_Valid and payload until accepted.

Reset
REQ-029 Asserting sync_rst SHALL immediately clear RegWriteEn, TagFreeValid, RegWriteAddrOut, RegWriteDataOut, TagFreeOut, GrantIndex to 0 and set LastGrant to 3 (port 0 first priority).
REQ-030 A transfer in the reset-release cycle is discarded; first transfer occurs the first clk edge with sync_rst low.

Configuration
REQ-031 Macro WB_ARB_LSU_PRIORITY_EN: defined -> Req_Valid[3] wins unconditionally and an LSU grant does not update LSU-excluded LastGrant; rotation continues over ports 0-2.
REQ-032 Macro undefined -> pure 4-way round-robin per REQ-021.

Structure
REQ-033 Package wb_arb_pkg SHALL hold PORTCOUNT=4 and port index constants (ALU0, ALU1, CALU, LSU).
REQ-034 Sub-module rr_picker4 SHALL implement combinational rotating priority (requests, LastGrant -> one-hot grant, index).

Verification
REQ-035 Reset then Req_Valid=4'b1111 held 4 cycles, clk_en=1 -> grants 0,1,2,3 in order; GrantIndex lags one cycle.
REQ-036 Single request port 2, addr 5, data 16'hBEEF, tag 6'h21 -> next cycle RegWriteEn=1, addr 5, data BEEF, TagFreeOut 21.
REQ-037 Port 1 request with addr 0 -> next cycle RegWriteEn=0, TagFreeValid=1, tag retired.
REQ-038 Req_Valid=4'b0011, clk_en=0 for 3 cycles -> Req_Ready=0, outputs hold, stall=1; clk_en=1 -> port 0 granted.
REQ-039 WB_ARB_LSU_PRIORITY_EN defined, Req_Valid=4'b1001 for 3 cycles -> port 3 granted every cycle; drop bit 3 -> port 0 granted.
REQ-040 sync_rst asserted mid-stream with valid output -> RegWriteEn, TagFreeValid fall immediately without clock; after release port 0 wins first.
